// File: rtl/uart_mem_pkg.sv
// uart_mem_pkg: shared state encoding and protocol byte values for the UART memory command parser.
// Revision 1.0
`default_nettype none

package uart_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h3F;

endpackage

`default_nettype wire

// File: rtl/uart_mem_cmd.sv
// uart_mem_cmd: parses W/R byte commands from a UART receiver, drives a debug RAM port
// and returns acknowledge or read-data bytes to the UART transmitter.  Revision 1.0
`default_nettype none

module uart_mem_cmd
    import uart_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  mem_wr_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int CW     = $clog2(NBYTES) + 1;
    localparam int TW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t                state_q, state_d;
    logic                  is_wr_q, is_wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] txsr_q, txsr_d;
    logic [7:0]            txd_q, txd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         tmo_q, tmo_d;

    logic rx_hs;
    logic tx_hs;
    logic tmo_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            txsr_q  <= '0;
            txd_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            txsr_q  <= txsr_d;
            txd_q   <= txd_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        txsr_d  = txsr_q;
        txd_d   = txd_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;

        rx_ready_o = (state_q == ST_IDLE) || (state_q == ST_ADDR) || (state_q == ST_WDATA);
        tx_valid_o = (state_q == ST_RESP);
        mem_wr_o   = (state_q == ST_WRITE);
        busy_o     = (state_q != ST_IDLE);

        rx_hs   = rx_valid_i && rx_ready_o;
        tx_hs   = tx_valid_o && tx_ready_i;
        // Abort on the idle cycle that would bring the count up to the limit.
        tmo_hit = (TIMEOUT_CYCLES != 0) && ((32'(tmo_q) + 32'd1) == 32'(TIMEOUT_CYCLES));

        case (state_q)
            ST_IDLE: begin
                if (rx_hs) begin
                    tmo_d = '0;
                    if (rx_data_i == CMD_WRITE) begin
                        is_wr_d = 1'b1;
                        state_d = ST_ADDR;
                    end else if (rx_data_i == CMD_READ) begin
                        is_wr_d = 1'b0;
                        state_d = ST_ADDR;
                    end else begin
                        txd_d   = RSP_ERR;
                        cnt_d   = CW'(1);
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_hs) begin
                    addr_d = rx_data_i[ADDR_WIDTH-1:0];
                    tmo_d  = '0;
                    cnt_d  = '0;
                    state_d = is_wr_q ? ST_WDATA : ST_READ;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_WDATA: begin
                if (rx_hs) begin
                    wdata_d = (wdata_q << 8) | DATA_WIDTH'(rx_data_i);
                    tmo_d   = '0;
                    if (cnt_q == CW'(NBYTES - 1)) begin
                        state_d = ST_WRITE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_WRITE: begin
                txd_d   = RSP_ACK;
                cnt_d   = CW'(1);
                state_d = ST_RESP;
            end
            ST_READ: begin
                // First byte goes straight to the output register; the rest queue in txsr.
                txd_d   = mem_rdata_i[DATA_WIDTH-1 -: 8];
                txsr_d  = mem_rdata_i << 8;
                cnt_d   = CW'(NBYTES);
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (tx_hs) begin
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d  = cnt_q - CW'(1);
                        txd_d  = txsr_q[DATA_WIDTH-1 -: 8];
                        txsr_d = txsr_q << 8;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tx_data_o   = txd_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_mem_cmd.sv
// tb_uart_mem_cmd: directed stimulus with a command-level model of expected RAM writes and tx bytes.
// Revision 1.0
`default_nettype none

module tb_uart_mem_cmd;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int TO = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    always #5 clk = ~clk;

    uart_mem_cmd #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .mem_wr_o   (mem_wr),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .busy_o     (busy)
    );

    // Debug RAM attached to the DUT: combinational read, synchronous write.
    logic [DW-1:0] ram [16];
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_wr) ram[mem_addr] <= mem_wdata;

    // Command-level model state.
    logic [DW-1:0]    exp_mem [16];
    logic [7:0]       exp_tx [$];
    logic [AW+DW-1:0] exp_wr [$];

    int checks   = 0;
    int failures = 0;
    int wr_count = 0;
    int tx_count = 0;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;
    logic [7:0]    last_tx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d1,
                             input logic [7:0] d0);
        logic [AW-1:0] ad;
        ad = a[AW-1:0];
        if (op == 8'h57) begin
            exp_wr.push_back({ad, d1, d0});
            exp_tx.push_back(8'h4B);
            exp_mem[ad] = {d1, d0};
        end else if (op == 8'h52) begin
            exp_tx.push_back(exp_mem[ad][15:8]);
            exp_tx.push_back(exp_mem[ad][7:0]);
        end else begin
            exp_tx.push_back(8'h3F);
        end
    endtask

    // Compare process: every RAM write and tx handshake is matched against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wr) begin
                wr_count++;
                last_wr_addr = mem_addr;
                last_wr_data = mem_wdata;
                if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none", mem_addr, mem_wdata);
                end else begin
                    check("write", {12'd0, mem_addr, mem_wdata}, {12'd0, exp_wr.pop_front()});
                end
            end
            if (tx_valid && tx_ready) begin
                tx_count++;
                last_tx = tx_data;
                if (exp_tx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tx: got %h expected none", tx_data);
                end else begin
                    check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
                end
            end
            check("rx_ready_exclusive", {31'd0, rx_ready & (tx_valid | mem_wr)}, 32'd0);
        end
    end

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic send_byte(input logic [7:0] b);
        logic hs;
        int   n;
        n = 0;
        hs = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = rx_ready;
            @(posedge clk);
            #1;
            n++;
        end
        rx_valid = 1'b0;
        if (!hs) begin
            checks++;
            failures++;
            $display("FAIL rx_handshake_timeout: got no rx_ready expected handshake for %h", b);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_tx.size() != 0 || exp_wr.size() != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_completes"}, {31'd0, (n < 200)}, 32'd1);
    endtask

    task automatic run_cmd(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input string name);
        model_cmd(b0, b1, b2, b3);
        send_byte(b0);
        if (nb > 1) send_byte(b1);
        if (nb > 2) send_byte(b2);
        if (nb > 3) send_byte(b3);
        wait_idle(name);
    endtask

    int wr0, tx0;
    logic [7:0] held;

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ram[i]     = 16'hA000 + 16'(i);
            exp_mem[i] = 16'hA000 + 16'(i);
        end
        #12;
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Write 57,03,BE,EF with cycle-exact timing.
        model_cmd(8'h57, 8'h03, 8'hBE, 8'hEF);
        send_byte(8'h57);
        send_byte(8'h03);
        send_byte(8'hBE);
        send_byte(8'hEF);
        @(negedge clk);
        check("wr_strobe", {31'd0, mem_wr}, 32'd1);
        check("wr_addr", {28'd0, mem_addr}, 32'd3);
        check("wr_data", {16'd0, mem_wdata}, 32'h0000BEEF);
        check("wr_no_tx_yet", {31'd0, tx_valid}, 32'd0);
        @(negedge clk);
        check("wr_strobe_one_cycle", {31'd0, mem_wr}, 32'd0);
        check("ack_valid", {31'd0, tx_valid}, 32'd1);
        check("ack_byte", {24'd0, tx_data}, 32'h4B);
        @(posedge clk);
        #1;
        wait_idle("write");

        // Read-back 52,03.
        wr0 = wr_count;
        tx0 = tx_count;
        model_cmd(8'h52, 8'h03, 8'h00, 8'h00);
        send_byte(8'h52);
        send_byte(8'h03);
        @(negedge clk);
        check("read_cycle_busy", {31'd0, busy}, 32'd1);
        check("read_cycle_no_tx", {31'd0, tx_valid}, 32'd0);
        @(negedge clk);
        check("read_msb_valid", {31'd0, tx_valid}, 32'd1);
        check("read_msb", {24'd0, tx_data}, 32'hBE);
        @(posedge clk);
        #1;
        wait_idle("read");
        check("read_no_write", wr_count - wr0, 32'd0);
        check("read_two_bytes", tx_count - tx0, 32'd2);
        check("read_last_byte", {24'd0, last_tx}, 32'hEF);
        check("read_busy_low", {31'd0, busy}, 32'd0);

        // Bad opcode, then a normal read.
        wr0 = wr_count;
        tx0 = tx_count;
        run_cmd(1, 8'h41, 8'h00, 8'h00, 8'h00, "bad_op");
        check("bad_op_reply", {24'd0, last_tx}, 32'h3F);
        check("bad_op_one_byte", tx_count - tx0, 32'd1);
        check("bad_op_no_write", wr_count - wr0, 32'd0);
        run_cmd(2, 8'h52, 8'h03, 8'h00, 8'h00, "read_after_bad");

        // Address truncation.
        run_cmd(4, 8'h57, 8'hF5, 8'h12, 8'h34, "trunc");
        check("trunc_addr", {28'd0, last_wr_addr}, 32'd5);
        check("trunc_data", {16'd0, last_wr_data}, 32'h1234);

        // Timeout: 57,02,AA then a long stall discards the command.
        wr0 = wr_count;
        tx0 = tx_count;
        send_byte(8'h57);
        send_byte(8'h02);
        send_byte(8'hAA);
        repeat (12) @(posedge clk);
        #1;
        check("timeout_idle", {31'd0, busy}, 32'd0);
        check("timeout_no_write", wr_count - wr0, 32'd0);
        check("timeout_no_tx", tx_count - tx0, 32'd0);
        check("timeout_addr_kept", {28'd0, mem_addr}, 32'd2);
        run_cmd(2, 8'h52, 8'h02, 8'h00, 8'h00, "read_after_timeout");
        check("timeout_old_data", {24'd0, last_tx}, 32'h02);

        // Nine idle cycles between bytes stay inside the timeout window.
        wr0 = wr_count;
        model_cmd(8'h57, 8'h06, 8'h00, 8'h07);
        send_byte(8'h57);
        send_byte(8'h06);
        repeat (9) @(posedge clk);
        #1;
        send_byte(8'h00);
        send_byte(8'h07);
        wait_idle("stall_9");
        check("stall_9_written", wr_count - wr0, 32'd1);
        check("stall_9_data", {16'd0, last_wr_data}, 32'h0007);

        // Backpressure during a read response, then reset mid-response.
        tx_ready = 1'b0;
        model_cmd(8'h52, 8'h03, 8'h00, 8'h00);
        send_byte(8'h52);
        send_byte(8'h03);
        repeat (3) @(negedge clk);
        check("bp_valid", {31'd0, tx_valid}, 32'd1);
        check("bp_first_byte", {24'd0, tx_data}, 32'hBE);
        held = tx_data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_data_stable", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, held});
        end
        #2 rst = 1'b1;
        #1;
        check("rst_async_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        exp_tx.delete();
        exp_wr.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tx_ready = 1'b1;
        run_cmd(2, 8'h52, 8'h05, 8'h00, 8'h00, "read_after_rst");
        check("after_rst_data", {24'd0, last_tx}, 32'h34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
